// File: rtl/weight_loader.sv
// Streams kernel weights then per-unit biases into weight memory in packed-unit layout.
// Latency: combinational pass-through from in_* to mem_*; done pulses the cycle after the last write.
// Backpressure: in_ready follows mem_ready while loading; no internal buffering.
module weight_loader #(
   parameter int N_UNITS = 16,
   parameter int DATA_W  = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [31:0]         start_addr,
   input  logic [7:0]          kernel_size,
   input  logic [N_UNITS-1:0]  active_units,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   output logic                in_ready,
   output logic                mem_we,
   output logic [31:0]         mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ready,
   output logic                busy,
   output logic                done
);

   localparam int IW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
   localparam int CW = $clog2(N_UNITS + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WEIGHTS = 2'd1;
   localparam logic [1:0] S_BIAS    = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [31:0]        addr_q, addr_d;          // weight write pointer
   logic [31:0]        bias_base_q, bias_base_d;
   logic [31:0]        wrem_q, wrem_d;          // weights still to be written
   logic [N_UNITS-1:0] pend_q, pend_d;          // active units whose bias is not yet written

   logic [CW-1:0]      a_cnt;
   logic [31:0]        weight_total;
   logic [IW-1:0]      bidx;
   logic [N_UNITS-1:0] pend_nxt;
   logic               accept;

   // Popcount of the incoming mask; only used on the start cycle.
   always_comb begin
      a_cnt = '0;
      for (int i = 0; i < N_UNITS; i++) begin
         a_cnt = a_cnt + CW'(active_units[i]);
      end
   end

   assign weight_total = 32'(a_cnt) * 32'(kernel_size);

   // Priority encoder: lowest-index unit still waiting for its bias.
   always_comb begin
      bidx     = '0;
      for (int i = N_UNITS - 1; i >= 0; i--) begin
         if (pend_q[i]) bidx = IW'(i);
      end
      pend_nxt       = pend_q;
      pend_nxt[bidx] = 1'b0;
   end

   assign in_ready  = ((state_q == S_WEIGHTS) || (state_q == S_BIAS)) && mem_ready;
   assign accept    = in_valid && in_ready;
   assign mem_we    = accept;
   assign mem_wdata = accept ? in_data : '0;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);

   // Bias slots are indexed by physical unit number, so inactive units leave holes.
   always_comb begin
      mem_addr = 32'd0;
      if (state_q == S_WEIGHTS)   mem_addr = addr_q;
      else if (state_q == S_BIAS) mem_addr = bias_base_q + 32'(bidx);
   end

   // Next-state logic: config latch on start, pointers advance only on accepted words.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      bias_base_d = bias_base_q;
      wrem_d      = wrem_q;
      pend_d      = pend_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d      = start_addr;
               bias_base_d = start_addr + weight_total;
               wrem_d      = weight_total;
               pend_d      = active_units;
               if (a_cnt == '0)              state_d = S_DONE;
               else if (kernel_size == 8'd0) state_d = S_BIAS;
               else                          state_d = S_WEIGHTS;
            end
         end
         S_WEIGHTS: begin
            if (accept) begin
               addr_d = addr_q + 32'd1;
               wrem_d = wrem_q - 32'd1;
               if (wrem_q == 32'd1) state_d = S_BIAS;
            end
         end
         S_BIAS: begin
            if (accept) begin
               pend_d = pend_nxt;
               if (pend_nxt == '0) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and pointer registers; reset aborts any load in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= 32'd0;
         bias_base_q <= 32'd0;
         wrem_q      <= 32'd0;
         pend_q      <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         bias_base_q <= bias_base_d;
         wrem_q      <= wrem_d;
         pend_q      <= pend_d;
      end
   end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader with N_UNITS=4: address/data order, timing of done, stalls, reset abort.
module tb_weight_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] start_addr;
   logic [7:0]  kernel_size;
   logic [3:0]  active_units;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic        busy;
   logic        done;

   weight_loader #(.N_UNITS(4), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .start_addr   (start_addr),
      .kernel_size  (kernel_size),
      .active_units (active_units),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ready    (mem_ready),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int viol = 0;
   logic [31:0] wa[$];
   logic [31:0] wd[$];
   logic [31:0] exp_a[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Record writes, done pulses and any in_ready while memory is stalled.
   always @(negedge clk) begin
      if (mem_we) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_wdata);
      end
      if (done) done_cnt++;
      if (!mem_ready && in_ready) viol++;
   end

   task automatic do_start(input logic [31:0] base, input logic [7:0] k, input logic [3:0] mask);
      wa.delete();
      wd.delete();
      done_cnt     = 0;
      start        = 1'b1;
      start_addr   = base;
      kernel_size  = k;
      active_units = mask;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
   endtask

   task automatic stream(input int nwords, input bit rnd, input int pulse_at, input logic [31:0] seed);
      int sent  = 0;
      int guard = 0;
      while (sent < nwords && guard < 2000) begin
         in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         mem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_data   = seed + sent;
         if (sent == pulse_at) begin
            start        = 1'b1;
            start_addr   = 32'h900;
            kernel_size  = 8'd5;
            active_units = 4'hF;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
         guard++;
      end
      start     = 1'b0;
      in_valid  = 1'b0;
      mem_ready = 1'b1;
      chk("stream_words_accepted", sent, nwords);
   endtask

   task automatic finish_check(input string tag);
      @(negedge clk);
      chk({tag, "_done_hi"}, {31'd0, done}, 32'd1);
      chk({tag, "_busy_hi"}, {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_done_lo"}, {31'd0, done}, 32'd0);
      chk({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic check_writes(input string tag, input logic [31:0] seed);
      chk({tag, "_nwrites"}, wa.size(), exp_a.size());
      for (int i = 0; i < exp_a.size() && i < wa.size(); i++) begin
         chk({tag, "_addr"}, wa[i], exp_a[i]);
         chk({tag, "_data"}, wd[i], seed + i);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start_addr = 32'd0; kernel_size = 8'd0;
      active_units = 4'd0; in_valid = 1'b0; in_data = 32'd0; mem_ready = 1'b1;
      #12;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_mem_we",   {31'd0, mem_we},   32'd0);
      chk("rst_mem_addr", mem_addr,          32'd0);
      chk("rst_wdata",    mem_wdata,         32'd0);
      chk("rst_busy",     {31'd0, busy},     32'd0);
      chk("rst_done",     {31'd0, done},     32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Full mask, K=3: 12 weights then 4 contiguous biases.
      do_start(32'h100, 8'd3, 4'b1111);
      stream(16, 1'b0, -1, 32'hA000_0000);
      finish_check("full");
      exp_a.delete();
      for (int i = 0; i < 16; i++) exp_a.push_back(32'h100 + i);
      check_writes("full", 32'hA000_0000);

      // Sparse mask: bias holes at 0x204 and 0x206.
      do_start(32'h200, 8'd2, 4'b1010);
      stream(6, 1'b0, -1, 32'hB000_0000);
      finish_check("sparse");
      exp_a = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h205, 32'h207};
      check_writes("sparse", 32'hB000_0000);

      // Same as the first load with random valid gaps and memory stalls.
      viol = 0;
      do_start(32'h100, 8'd3, 4'b1111);
      stream(16, 1'b1, -1, 32'hC000_0000);
      finish_check("stall");
      exp_a.delete();
      for (int i = 0; i < 16; i++) exp_a.push_back(32'h100 + i);
      check_writes("stall", 32'hC000_0000);
      chk("stall_ready_while_mem_busy", viol, 0);

      // Empty mask: done at t+1 with no writes.
      do_start(32'h500, 8'd4, 4'b0000);
      finish_check("empty");
      chk("empty_nwrites", wa.size(), 0);

      // K=0: biases only.
      do_start(32'h40, 8'd0, 4'b0011);
      stream(2, 1'b0, -1, 32'hD000_0000);
      finish_check("k0");
      exp_a = '{32'h40, 32'h41};
      check_writes("k0", 32'hD000_0000);

      // Reset after 5 accepted words aborts immediately.
      do_start(32'h100, 8'd3, 4'b1111);
      stream(5, 1'b0, -1, 32'hE000_0000);
      chk("pre_rst_nwrites", wa.size(), 5);
      in_valid = 1'b1; mem_ready = 1'b1; rst = 1'b1;
      #1;
      chk("abort_outputs", {28'd0, in_ready, mem_we, busy, done}, 32'd0);
      chk("abort_mem_addr", mem_addr, 32'd0);
      chk("abort_wdata", mem_wdata, 32'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      do_start(32'h10, 8'd1, 4'b0001);
      stream(2, 1'b0, -1, 32'hF000_0000);
      finish_check("post_rst");
      exp_a = '{32'h10, 32'h11};
      check_writes("post_rst", 32'hF000_0000);

      // Start pulse and config changes mid-load are ignored.
      do_start(32'h300, 8'd2, 4'b0101);
      stream(6, 1'b0, 2, 32'h1234_0000);
      finish_check("midcfg");
      repeat (3) @(posedge clk);
      #1;
      exp_a = '{32'h300, 32'h301, 32'h302, 32'h303, 32'h304, 32'h306};
      check_writes("midcfg", 32'h1234_0000);
      chk("midcfg_done_pulses", done_cnt, 1);
      chk("midcfg_idle_after", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/weight_loader.md
# weight_loader

Writes a streamed set of kernel weights and biases into weight memory. The layout it produces is the one the per-unit pointer array reads: each active unit's kernel is contiguous and packed in ascending unit order, followed by the bias region. It sits between the host/DMA input stream and the weight memory write port, and runs once per layer load.

## Interface
- N_UNITS, 16, number of compute units (width of active_units)
- DATA_W, 32, weight/bias word width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a load; honoured only in IDLE
- start_addr  in  32  base address of the weight region
- kernel_size  in  8  words per unit kernel (K)
- active_units  in  N_UNITS  mask of units receiving weights
- in_valid  in  1  input word valid
- in_data  in  DATA_W  input word
- in_ready  out  1  loader accepts in_data this cycle
- mem_we  out  1  memory write strobe
- mem_addr  out  32  write address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  memory accepts the write this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the load completes

## Operation
- Config latch: start_addr, kernel_size and active_units are registered on an accepted start. Later changes to these inputs are ignored until the next start.
- A = popcount(latched mask). bias_base = start_addr + A*K, computed in 32 bits and wrapping mod 2^32.
- Word order expected on the stream:
  - First A*K weights, grouped by unit: all K words of the lowest-index active unit, then the next active unit, and so on.
  - Then A biases, one per active unit, in ascending unit index.
- Weight addresses: the k-th active unit (k counted from 0) writes word j to start_addr + k*K + j. The weight region is contiguous, so a single write pointer starts at start_addr and increments by 1 per accepted word.
- Bias addresses: the bias for active unit i is written to bias_base + i. The offset is the physical unit index i, not the rank k, so inactive units leave holes in the bias region.
- FSM states IDLE, WEIGHTS, BIAS, DONE:
  - IDLE: start=1 and A>0 and K>0 -> WEIGHTS. start=1 and A>0 and K=0 -> BIAS. start=1 and A=0 -> DONE.
  - WEIGHTS: after the (A*K)-th accepted word -> BIAS.
  - BIAS: a unit pointer walks the set bits of the latched mask; a priority encoder over the not-yet-written bits selects the next one. After the A-th accepted bias -> DONE.
  - DONE: done=1 for this one cycle -> IDLE.
- Handshake:
  - in_ready = (state is WEIGHTS or BIAS) & mem_ready.
  - A word is accepted when in_valid & in_ready.
  - mem_we = in_valid & in_ready, mem_wdata = in_data, and mem_addr is the current pointer. This path is combinational pass-through with no buffering.
  - Pointers and counters advance only on an accepted word.
- start while busy: ignored and not queued.
- Extra stream words after the final accepted word: not accepted, because in_ready=0 outside WEIGHTS/BIAS.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0 (gated by mem_we), busy=0, done=0. State is IDLE and all counters and pointers are 0.
- Reset mid-operation: the block aborts immediately to IDLE. Writes already performed are not undone. The next start begins a fresh load.
- Start accepted in cycle t: busy=1 from t+1 and in_ready may be 1 from t+1.
- Throughput: one word per cycle while in_valid and mem_ready are both high. Total words = A*K + A.
- Final word accepted in cycle u: state is DONE with done=1 in cycle u+1, and IDLE with busy=0 in cycle u+2.
- A=0: done=1 at t+1, with no writes.
- Back-to-back loads: the earliest next start is accepted in cycle u+2.

## Test plan
- N_UNITS=4, mask=4'b1111, start_addr=0x100, K=3, 16 words streamed continuously -> weights written to 0x100..0x10B, biases to 0x10C..0x10F in order, done pulse in the cycle after the 16th write.
- mask=4'b1010, start_addr=0x200, K=2, 6 words -> weights to 0x200,0x201 (unit 1) and 0x202,0x203 (unit 3); biases to 0x205 and 0x207; no write to 0x204 or 0x206.
- Same configuration as the first scenario with random in_valid gaps and random mem_ready stalls -> identical address/data sequence, exactly 16 mem_we pulses, in_ready=0 in every cycle where mem_ready=0.
- Degenerate cases:
  - mask=0 -> done at t+1 and no mem_we.
  - mask=4'b0011, K=0, start_addr=0x40 -> only biases written, to 0x40 and 0x41.
- Assert rst after 5 accepted words -> all outputs 0 in the same cycle. A new start with mask=4'b0001, K=1, start_addr=0x10 then writes 0x10 and 0x11 and pulses done.
- Pulse start and change start_addr/mask/K mid-load -> no effect: addresses follow the originally latched config and exactly one done pulse is produced.
